// File: rtl/muldiv_pkg.sv
// Shared definitions for the execute-stage multiply/divide unit: op and state
// encodings plus the width-generic conditional two's-complement negate.
package muldiv_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_MADD  = 3'd2,
    MD_MADDU = 3'd3,
    MD_MSUB  = 3'd4,
    MD_MSUBU = 3'd5,
    MD_DIV   = 3'd6,
    MD_DIVU  = 3'd7
  } md_op_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_ACC  = 3'd2,
    S_DIV  = 3'd3,
    S_DIVZ = 3'd4,
    S_DONE = 3'd5
  } md_state_e;

  // Widest value md_cneg handles; callers zero-extend in and truncate out,
  // which is exact because the low bits of a negation ignore the high bits.
  localparam int MD_MAXW = 128;

  // Quotient word reported for a zero divisor.
  localparam logic [MD_MAXW-1:0] MD_DIVZ_LO = '1;

  function automatic logic [MD_MAXW-1:0] md_cneg(input logic [MD_MAXW-1:0] v,
                                                 input logic               neg);
    return neg ? (~v + MD_MAXW'(1)) : v;
  endfunction

endpackage

// File: rtl/ex_muldiv_mul_pipe.sv
// Unsigned magnitude multiplier: product enters on the launch edge and then
// ripples through MUL_STAGES registers alongside a matching valid shifter.
module mul_pipe #(
  parameter int DATA_W     = 32,
  parameter int MUL_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush_i,
  input  logic                vld_i,
  input  logic [DATA_W-1:0]   a_i,
  input  logic [DATA_W-1:0]   b_i,
  output logic                vld_o,
  output logic [2*DATA_W-1:0] prod_o
);

  localparam int PW = 2 * DATA_W;

  logic [MUL_STAGES-1:0]         vld_pipe;
  logic [MUL_STAGES-1:0][PW-1:0] stg_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_pipe <= '0;
      stg_q    <= '0;
    end else begin
      vld_pipe[0] <= vld_i & ~flush_i;
      if (vld_i) stg_q[0] <= PW'(a_i) * PW'(b_i);
      for (int s = 1; s < MUL_STAGES; s++) begin
        vld_pipe[s] <= vld_pipe[s-1] & ~flush_i;
        stg_q[s]    <= stg_q[s-1];
      end
    end
  end

  assign vld_o  = vld_pipe[MUL_STAGES-1];
  assign prod_o = stg_q[MUL_STAGES-1];

endmodule

// File: rtl/ex_muldiv.sv
// Multi-cycle multiply / multiply-accumulate / divide unit for the execute
// stage; stalls while busy and pulses ready_o with a {HI,LO} result.
module ex_muldiv
  import muldiv_pkg::*;
#(
  parameter int DATA_W           = 32,
  parameter int MUL_STAGES       = 2,
  parameter int DIV_BITS_PER_CYC = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic [2:0]          op_i,
  input  logic [DATA_W-1:0]   opdata1_i,
  input  logic [DATA_W-1:0]   opdata2_i,
  input  logic [2*DATA_W-1:0] hilo_i,
  input  logic                annul_i,
  output logic [2*DATA_W-1:0] result_o,
  output logic                ready_o,
  output logic                stallreq_o
);

  localparam int PW      = 2 * DATA_W;
  localparam int DIV_CYC = DATA_W / DIV_BITS_PER_CYC;
  localparam int CW      = $clog2(DIV_CYC + 1);

  if ((DATA_W % DIV_BITS_PER_CYC) != 0 || MUL_STAGES < 1) begin : g_bad_cfg
    $error("ex_muldiv: unsupported parameter combination");
  end

  md_state_e         state_q, state_d;
  md_op_e            op_q;
  logic              neg_q, rsgn_q;
  logic [PW-1:0]     hilo_q, prod_q, result_q, result_d;
  logic [DATA_W-1:0] dvd_q, den_q, rem_q;
  logic [CW-1:0]     cnt_q;

  // Launch-side decode straight off the inputs.
  md_op_e            op_in;
  logic              in_signed, is_div_in, div_zero, s1, s2, accept;
  logic [DATA_W-1:0] mag1, mag2;

  assign op_in     = md_op_e'(op_i);
  assign in_signed = op_in inside {MD_MULT, MD_MADD, MD_MSUB, MD_DIV};
  assign is_div_in = op_in inside {MD_DIV, MD_DIVU};
  assign div_zero  = (opdata2_i == '0);
  assign s1        = in_signed & opdata1_i[DATA_W-1];
  assign s2        = in_signed & opdata2_i[DATA_W-1];
  assign mag1      = DATA_W'(md_cneg(MD_MAXW'(opdata1_i), s1));
  assign mag2      = DATA_W'(md_cneg(MD_MAXW'(opdata2_i), s2));
  assign accept    = (state_q == S_IDLE) & start_i & ~annul_i;

  logic          mul_vld;
  logic [PW-1:0] mul_prod, prod_adj, acc_res;

  mul_pipe #(
    .DATA_W     (DATA_W),
    .MUL_STAGES (MUL_STAGES)
  ) u_mul (
    .clk     (clk),
    .rst     (rst),
    .flush_i (annul_i),
    .vld_i   (accept & ~is_div_in),
    .a_i     (mag1),
    .b_i     (mag2),
    .vld_o   (mul_vld),
    .prod_o  (mul_prod)
  );

  assign prod_adj = PW'(md_cneg(MD_MAXW'(mul_prod), neg_q));
  assign acc_res  = (op_q inside {MD_MADD, MD_MADDU}) ? hilo_q + prod_q
                                                      : hilo_q - prod_q;

  // Restoring divide: dvd_q shifts dividend bits out the top while quotient
  // bits fill in from the bottom, so it ends up holding the quotient.
  logic [DATA_W-1:0] dr, dq, quo_fix, rem_fix;
  logic [DATA_W:0]   dt;
  logic              div_last;

  always_comb begin
    dr = rem_q;
    dq = dvd_q;
    dt = '0;
    for (int i = 0; i < DIV_BITS_PER_CYC; i++) begin
      dt = {dr, dq[DATA_W-1]};
      dq = {dq[DATA_W-2:0], 1'b0};
      if (dt >= {1'b0, den_q}) begin
        dt    = dt - {1'b0, den_q};
        dq[0] = 1'b1;
      end
      dr = dt[DATA_W-1:0];
    end
  end

  assign quo_fix  = DATA_W'(md_cneg(MD_MAXW'(dq), neg_q));
  assign rem_fix  = DATA_W'(md_cneg(MD_MAXW'(dr), rsgn_q));
  assign div_last = (cnt_q == CW'(DIV_CYC - 1));

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    unique case (state_q)
      S_IDLE: if (accept) state_d = !is_div_in ? S_MUL : (div_zero ? S_DIVZ : S_DIV);
      S_MUL: begin
        if (mul_vld) begin
          if (op_q inside {MD_MULT, MD_MULTU}) begin
            state_d  = S_DONE;
            result_d = prod_adj;
          end else begin
            state_d = S_ACC;
          end
        end
      end
      S_ACC: begin
        state_d  = S_DONE;
        result_d = acc_res;
      end
      S_DIV: begin
        if (div_last) begin
          state_d  = S_DONE;
          result_d = {rem_fix, quo_fix};
        end
      end
      S_DIVZ: begin
        state_d  = S_DONE;
        result_d = {dvd_q, DATA_W'(MD_DIVZ_LO)};
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (annul_i) begin
      state_d  = S_IDLE;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      result_q <= '0;
      op_q     <= MD_MULT;
      neg_q    <= 1'b0;
      rsgn_q   <= 1'b0;
      hilo_q   <= '0;
      prod_q   <= '0;
      dvd_q    <= '0;
      den_q    <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
    end else begin
      result_q <= result_d;
      if (accept) begin
        op_q   <= op_in;
        hilo_q <= hilo_i;
        neg_q  <= s1 ^ s2;
        rsgn_q <= s1;
        den_q  <= mag2;
        // A zero divisor reports the raw dividend, so keep it unconverted.
        dvd_q  <= div_zero ? opdata1_i : mag1;
        rem_q  <= '0;
        cnt_q  <= '0;
      end
      if (state_q == S_MUL && mul_vld) prod_q <= prod_adj;
      if (state_q == S_DIV) begin
        rem_q <= dr;
        dvd_q <= dq;
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign result_o   = result_q;
  assign ready_o    = (state_q == S_DONE) & ~annul_i;
  // Dropping the stall in DONE lets the pipeline advance as ready_o is consumed.
  assign stallreq_o = rst & ~annul_i &
                      ((state_q == S_IDLE) ? start_i : (state_q != S_DONE));

endmodule

// File: tb/tb_ex_muldiv.sv
// Scoreboard bench for ex_muldiv: directed corner cases, annul/reset/busy-start
// scenarios and random ops checked against a plain-arithmetic model.
module tb_ex_muldiv;

  localparam int DATA_W     = 32;
  localparam int MUL_STAGES = 2;
  localparam int DIV_BPC    = 1;

  logic        clk, rst, start_i, annul_i;
  logic [2:0]  op_i;
  logic [31:0] opdata1_i, opdata2_i;
  logic [63:0] hilo_i, result_o;
  logic        ready_o, stallreq_o;

  ex_muldiv #(
    .DATA_W           (DATA_W),
    .MUL_STAGES       (MUL_STAGES),
    .DIV_BITS_PER_CYC (DIV_BPC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .op_i       (op_i),
    .opdata1_i  (opdata1_i),
    .opdata2_i  (opdata2_i),
    .hilo_i     (hilo_i),
    .annul_i    (annul_i),
    .result_o   (result_o),
    .ready_o    (ready_o),
    .stallreq_o (stallreq_o)
  );

  typedef struct {
    logic [63:0] res;
    int          rdy;
    int          op;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0, n_err = 0, cyc = 0, exp_rdy = 0;
  logic [63:0] last_exp = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: straight 64-bit arithmetic on the architectural meaning.
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, b,
                                        input logic [63:0] h);
    longint      sa, sb_, q, r;
    logic [63:0] p;
    sa  = longint'($signed(a));
    sb_ = longint'($signed(b));
    p   = (op inside {3'd0, 3'd2, 3'd4}) ? 64'(sa * sb_) : ({32'b0, a} * {32'b0, b});
    case (op)
      3'd0, 3'd1: return p;
      3'd2, 3'd3: return h + p;
      3'd4, 3'd5: return h - p;
      3'd6: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        q = sa / sb_;
        r = sa % sb_;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  function automatic int lat(input logic [2:0] op, input logic [31:0] b);
    if (op <= 3'd1) return MUL_STAGES + 1;
    if (op <= 3'd5) return MUL_STAGES + 2;
    if (b == 0)     return 2;
    return DATA_W / DIV_BPC + 1;
  endfunction

  function automatic logic [31:0] rnd32();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic scramble();
    op_i      = 3'($urandom);
    opdata1_i = $urandom;
    opdata2_i = $urandom;
    hilo_i    = {$urandom, $urandom};
  endtask

  // Monitor: every ready pulse must match the oldest expectation, on time.
  always @(negedge clk) begin
    if (rst && ready_o) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_ready: got result %h with no operation pending (cycle %0d)",
                 result_o, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk($sformatf("result_op%0d", e.op), result_o, e.res);
        chk($sformatf("latency_op%0d", e.op), 64'(cyc), 64'(e.rdy));
        chk("stall_in_done", 64'(stallreq_o), 64'd0);
        last_exp = e.res;
      end
    end
  end

  task automatic wait_idle();
    for (int k = 0; k < 200; k++) begin
      if (sb.size() == 0) return;
      if (cyc < exp_rdy) chk("stall_busy", 64'(stallreq_o), 64'd1);
      @(posedge clk); #1;
    end
    n_cmp++;
    n_err++;
    $display("FAIL timeout: %0d results still pending, expected none", sb.size());
    sb.delete();
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, b, input logic [63:0] h,
                       input bit push, input bit do_wait);
    exp_t e;
    op_i = op; opdata1_i = a; opdata2_i = b; hilo_i = h; start_i = 1'b1;
    #1;
    chk("stall_start", 64'(stallreq_o), 64'd1);
    if (push) begin
      e.res = model(op, a, b, h);
      e.rdy = cyc + lat(op, b);
      e.op  = op;
      sb.push_back(e);
      exp_rdy = e.rdy;
    end
    @(posedge clk); #1;
    start_i = 1'b0;
    scramble();
    if (do_wait) wait_idle();
  endtask

  initial begin
    rst = 1'b0; start_i = 1'b0; annul_i = 1'b0;
    op_i = '0; opdata1_i = '0; opdata2_i = '0; hilo_i = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_result", result_o, 64'd0);
    chk("reset_ready", 64'(ready_o), 64'd0);
    chk("reset_stall", 64'(stallreq_o), 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Directed corner cases
    issue(3'd0, 32'hFFFF_FFFE, 32'h0000_0003, 64'h0, 1, 1);
    issue(3'd5, 32'h4, 32'h5, 64'h0000_0000_0000_0010, 1, 1);
    issue(3'd2, 32'h8000_0000, 32'h8000_0000, 64'h0, 1, 1);
    issue(3'd6, 32'hFFFF_FFF9, 32'h2, 64'h0, 1, 1);
    issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0, 1, 1);
    issue(3'd7, 32'd100, 32'd0, 64'h0, 1, 1);
    issue(3'd4, 32'hFFFF_FFFF, 32'h7, 64'h1234_5678_9ABC_DEF0, 1, 1);
    issue(3'd6, 32'hFFFF_FFF9, 32'h0, 64'h0, 1, 1);

    // Annul a DIVU mid-flight, then launch right behind it
    issue(3'd7, 32'd1000, 32'd7, 64'h0, 0, 0);
    repeat (9) begin @(posedge clk); #1; end
    annul_i = 1'b1;
    #1;
    chk("stall_annul", 64'(stallreq_o), 64'd0);
    @(posedge clk); #1;
    annul_i = 1'b0;
    chk("annul_hold", result_o, last_exp);
    issue(3'd1, 32'hDEAD_BEEF, 32'h1234_5678, 64'h0, 1, 1);

    // annul together with start in IDLE launches nothing
    start_i = 1'b1; annul_i = 1'b1; op_i = 3'd0;
    #1;
    chk("stall_annul_start", 64'(stallreq_o), 64'd0);
    @(posedge clk); #1;
    start_i = 1'b0; annul_i = 1'b0;
    repeat (6) begin @(posedge clk); #1; end
    chk("annul_start_hold", result_o, last_exp);

    // start pulses during a busy DIV must not disturb it
    issue(3'd6, 32'hC000_1234, 32'h0000_0135, 64'h0, 1, 0);
    for (int k = 1; k <= 30; k++) begin
      chk("stall_busy_div", 64'(stallreq_o), 64'd1);
      start_i = 1'($urandom_range(0, 1));
      scramble();
      @(posedge clk); #1;
    end
    start_i = 1'b0;
    wait_idle();

    // Asynchronous reset mid-MUL, between clock edges
    issue(3'd7, 32'd100, 32'd0, 64'h0, 1, 1);
    issue(3'd0, 32'h1234_5678, 32'h9ABC_DEF0, 64'h0, 1, 0);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_result", result_o, 64'd0);
    chk("async_rst_ready", 64'(ready_o), 64'd0);
    chk("async_rst_stall", 64'(stallreq_o), 64'd0);
    sb.delete();
    last_exp = '0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

    // Random ops, back to back
    for (int n = 0; n < 120; n++) begin
      logic [2:0] op;
      op = 3'($urandom_range(0, 7));
      issue(op, rnd32(), rnd32(), {rnd32(), rnd32()}, 1, 1);
    end

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ex_muldiv.md
Name: ex_muldiv

Overview:
- Parametrised multi-cycle multiply/divide unit for the execute stage. It replaces the in-stage two-cycle madd/msub counter scheme.
- Executes mult/multu, madd/maddu, msub/msubu and div/divu from a single start pulse.
- Stalls the pipeline while busy and returns a 2*DATA_W {HI,LO} result with a one-cycle ready pulse.
- The execute stage drives it and forwards result_o to the HI/LO write path.

Parameters:
- DATA_W, 32, operand width in bits; HI and LO are each DATA_W.
- MUL_STAGES, 2, register stages in the multiplier path (>=1). Multiply latency follows from this value.
- DIV_BITS_PER_CYC, 1, quotient bits retired per divide cycle (1 or 2). DATA_W must be divisible by it.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset; resets the state regardless of clk
- start_i  in  1  launch request; sampled only in IDLE
- op_i  in  3  operation: 0 MULT, 1 MULTU, 2 MADD, 3 MADDU, 4 MSUB, 5 MSUBU, 6 DIV, 7 DIVU
- opdata1_i  in  DATA_W  multiplicand / dividend
- opdata2_i  in  DATA_W  multiplier / divisor
- hilo_i  in  2*DATA_W  forwarded {HI,LO}; used by accumulate ops
- annul_i  in  1  flush; abandons the operation in flight
- result_o  out  2*DATA_W  {HI,LO}; for divides HI=remainder, LO=quotient
- ready_o  out  1  one-cycle pulse when result_o is valid
- stallreq_o  out  1  pipeline stall request

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, result_o=0, ready_o=0, stallreq_o=0, all internal counters and operand registers =0.
- States: IDLE, MUL, ACC, DIV, DIVZ, DONE.
- IDLE exit on start_i=1 with annul_i=0. Operands, op_i and hilo_i are captured on that edge; inputs are don't-care afterwards.
  - op 0-5 -> MUL
  - op 6-7 with opdata2_i!=0 -> DIV
  - op 6-7 with opdata2_i==0 -> DIVZ
- MUL:
  - Operands are converted to magnitudes when the op is signed (0, 2, 4).
  - The product travels through MUL_STAGES registers.
  - The result is negated when the signed op has sign1^sign2.
  - Then go to DONE for ops 0-1, or to ACC for ops 2-5.
- ACC: one cycle computing hilo_captured + product (MADD/MADDU) or hilo_captured - product (MSUB/MSUBU), modulo 2^(2*DATA_W). Then go to DONE.
- DIV:
  - Restoring shift-subtract on magnitudes, retiring DIV_BITS_PER_CYC bits per cycle.
  - The counter runs DATA_W/DIV_BITS_PER_CYC cycles, then goes to DONE.
  - Signed fixup happens on entry to DONE: quotient sign = sign1^sign2; remainder sign = dividend sign.
  - DIV of the most negative value by -1 gives quotient = most negative value (wrap), remainder 0.
- DIVZ: one cycle, then DONE with result_o={opdata1 captured, all-ones}. This is a defined value, not an exception.
- DONE:
  - result_o is registered and ready_o=1 for exactly this cycle.
  - Next state is IDLE. result_o holds its value until the next DONE.
- Latency, start edge to ready cycle:
  - MULT/MULTU: MUL_STAGES+1
  - MADD-class: MUL_STAGES+2
  - DIV/DIVU: DATA_W/DIV_BITS_PER_CYC+1
  - divide-by-zero: 2
- stallreq_o is combinational:
  - 1 when start_i is accepted in IDLE, and in every non-IDLE state except DONE.
  - 0 in DONE, so the pipeline advances on the same edge that ready_o is consumed.
- start_i while not in IDLE: ignored, with no effect on the operation in flight.
- annul_i=1 in any state: next state IDLE, no ready_o pulse, result_o unchanged, stallreq_o=0 in that same cycle.
  - annul_i and start_i together in IDLE: annul wins and nothing is launched.
- A start may be accepted in the IDLE cycle that directly follows DONE, giving back-to-back operations with no bubble beyond that IDLE cycle.

Decomposition:
- Shared package muldiv_pkg:
  - op encodings (MD_MULT..MD_DIVU)
  - FSM state encoding
  - DIVZ lo constant (all-ones)
- The package also holds the helper function for two's-complement magnitude/negate.
- One sub-module, mul_pipe:
  - parameters DATA_W and MUL_STAGES
  - unsigned magnitude product with a valid shift register
  - instantiated once
- The divider datapath stays inline.

Test Plan:
- MULT: 0xFFFFFFFE x 0x00000003 -> result_o=0xFFFFFFFF_FFFFFFFA, ready_o 3 cycles after start (MUL_STAGES=2), stallreq_o high for cycles 0-2.
- MSUBU: hilo_i=0x00000000_00000010, 0x4 x 0x5 -> 0xFFFFFFFF_FFFFFFFC. MADD with 0x80000000 x 0x80000000 and hilo_i=0 -> 0x40000000_00000000.
- DIV: -7 / 2 -> HI=0xFFFFFFFF (rem -1), LO=0xFFFFFFFD (quot -3), ready 33 cycles after start. DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU: 100 / 0 -> result_o={0x00000064, 0xFFFFFFFF} after 2 cycles.
- annul_i asserted on cycle 10 of a DIVU -> state IDLE next cycle, no ready_o, result_o keeps the prior value. A start_i in the following cycle completes normally.
- rst pulled low mid-MUL, between clock edges -> all outputs 0 immediately. start_i pulses during a busy DIV are ignored, and the DIV result matches an undisturbed run.
